axi4lite_master_bridge: RTL and testbench
=========================================

# axi4lite_master_bridge

Single-outstanding AXI4-Lite initiator that turns a simple request/response command port into AXI4-Lite read and write transactions. It drives Cheby-generated AXI4-Lite register banks, for example from a debug UART/JTAG bridge or a test sequencer. It uses the same clock and reset as the target register bank. A programmable timeout recovers the command port from a dead or unmapped slave.

## Interface
Parameters:
- ADDR_WIDTH, 3, AXI address width (byte address).
- TIMEOUT, 1024, cycles allowed per transaction before abort; 0 disables; max 65535.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  command present.
- req_ready  out  1  command accepted when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  write data.
- req_wstrb  in  4  write byte strobes; ignored for reads.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  AXI BRESP or RRESP; 2'b10 on timeout.
- rsp_timeout  out  1  qualifies rsp_valid; transaction aborted.
- awvalid/awready/awaddr[ADDR_WIDTH]/awprot[3], wvalid/wready/wdata[32]/wstrb[4], bvalid/bready/bresp[2]: AXI write channels, master side.
- arvalid/arready/araddr[ADDR_WIDTH]/arprot[3], rvalid/rready/rdata[32]/rresp[2]: AXI read channels, master side.

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA.
- req_ready = (state == IDLE).
- Acceptance in IDLE:
  - Register addr, wdata and wstrb.
  - Write: go to WADDR with awvalid=wvalid=1.
  - Read: go to RADDR with arvalid=1.
- WADDR:
  - awvalid drops on the cycle after awvalid&awready.
  - wvalid drops independently on the cycle after wvalid&wready.
  - When both handshakes are complete, either in the same cycle or in different cycles, go to WRESP.
- WRESP:
  - bready=1.
  - On bvalid, capture bresp, pulse rsp_valid next cycle with rsp_rdata=0, and go to IDLE.
- RADDR:
  - arvalid=1 until arready, then go to RDATA.
- RDATA:
  - rready=1.
  - On rvalid, capture rdata and rresp, pulse rsp_valid, and go to IDLE.
- awaddr, araddr, wdata and wstrb stay stable from acceptance until their handshake completes.
- awprot = arprot = 3'b000 constant.
- A B or R beat outside WRESP/RDATA is never acknowledged (bready/rready low).
- Timeout:
  - A 16-bit counter clears on acceptance and increments each non-IDLE cycle.
  - When the counter equals TIMEOUT and no completing B/R handshake occurs that cycle, the block aborts:
    - All AXI valid/ready outputs go to 0.
    - rsp_valid=1, rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
    - The FSM returns to IDLE.
  - Dropping valid before its handshake is a deliberate, documented violation, reserved for dead-slave recovery.
  - A completing handshake in the timeout cycle takes precedence, giving a normal response.
- Reset (areset_n=0 at an edge):
  - The FSM goes to IDLE.
  - awvalid, wvalid, arvalid, bready, rready, rsp_valid and rsp_timeout reset to 0.
  - rsp_rdata and rsp_resp reset to 0; the counter resets to 0.
  - req_ready reads 1 after the first reset edge.
  - A reset mid-transaction discards it with no response.

## Timing
- Edge 0: command accepted. Cycle 1: awvalid/wvalid or arvalid high (registered).
- Zero-wait slave (all readies high, B/R one cycle after address/data):
  - Cycle 1: AW/W handshake. Cycle 2: WRESP, B handshake. Cycle 3: rsp_valid.
  - A write therefore takes 3 cycles from acceptance to response, and a read also takes 3.
- rsp_valid is high for exactly 1 cycle. The next command is accepted no earlier than the rsp_valid cycle (req_ready=1 then).
- Timeout response appears in cycle TIMEOUT+1 after acceptance.

## Test plan
- Write 0xDEADBEEF, wstrb 0xF, to addr 0x4 on an always-ready slave:
  - One AW/W handshake each, with awaddr=0x4 and wdata stable.
  - rsp_valid in cycle 3 with rsp_resp=00.
- Read from addr 0x0, with the slave returning 0x12345678 and RRESP=00 two cycles after arready:
  - rsp_rdata=0x12345678, rsp_resp=00, one pulse.
- Write with wready delayed 5 cycles behind awready:
  - awvalid drops after its handshake; wvalid holds until cycle 6.
  - bready is not asserted before both handshakes complete.
- Slave returns BRESP=10 for a write:
  - rsp_resp=10, rsp_timeout=0.
- TIMEOUT=8, slave never asserts arready:
  - arvalid drops and rsp_valid/rsp_timeout=1, rsp_resp=10 in cycle 9.
  - req_ready=1 afterwards.
- areset_n=0 for one cycle during WRESP:
  - All outputs return to 0 and no rsp_valid is issued.
  - A subsequent read completes normally.

Source files
------------

// File: rtl/axi4lite_master_bridge.sv
// rtl/axi4lite_master_bridge.sv - single-outstanding AXI4-Lite initiator behind a request/response command port
// A programmable cycle timeout aborts a stuck transaction and returns SLVERR with rsp_timeout set.
module axi4lite_master_bridge #(
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp
);

  typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA} state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [15:0]           cnt;
  logic [15:0]           cnt_inc;
  logic                  timeout_hit;

  logic                  accept;
  logic                  awvalid_nxt, wvalid_nxt, arvalid_nxt;
  logic                  rsp_set, rsp_to_set;
  logic [1:0]            rsp_resp_set;
  logic [31:0]           rsp_rdata_set;

  assign req_ready = (state == S_IDLE);
  assign bready    = (state == S_WRESP);
  assign rready    = (state == S_RDATA);
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;

  // Compare against the post-increment count so the abort lands on cycle TIMEOUT after acceptance.
  assign cnt_inc     = cnt + 16'd1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_C);

  always_comb begin
    state_nxt     = state;
    awvalid_nxt   = awvalid;
    wvalid_nxt    = wvalid;
    arvalid_nxt   = arvalid;
    accept        = 1'b0;
    rsp_set       = 1'b0;
    rsp_to_set    = 1'b0;
    rsp_resp_set  = 2'b00;
    rsp_rdata_set = 32'd0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_write) begin
            state_nxt   = S_WADDR;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
          end else begin
            state_nxt   = S_RADDR;
            arvalid_nxt = 1'b1;
          end
        end
      end
      S_WADDR: begin
        awvalid_nxt = awvalid & ~awready;
        wvalid_nxt  = wvalid & ~wready;
        if (!awvalid_nxt && !wvalid_nxt) state_nxt = S_WRESP;
      end
      S_WRESP: begin
        if (bvalid) begin
          rsp_set      = 1'b1;
          rsp_resp_set = bresp;
          state_nxt    = S_IDLE;
        end
      end
      S_RADDR: begin
        if (arready) begin
          arvalid_nxt = 1'b0;
          state_nxt   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (rvalid) begin
          rsp_set       = 1'b1;
          rsp_resp_set  = rresp;
          rsp_rdata_set = rdata;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort drops pending valids without a handshake; only B/R completion in this cycle wins.
    if (state != S_IDLE && timeout_hit && !rsp_set) begin
      state_nxt     = S_IDLE;
      awvalid_nxt   = 1'b0;
      wvalid_nxt    = 1'b0;
      arvalid_nxt   = 1'b0;
      rsp_set       = 1'b1;
      rsp_to_set    = 1'b1;
      rsp_resp_set  = 2'b10;
      rsp_rdata_set = 32'd0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state       <= S_IDLE;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      arvalid     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_resp    <= 2'b00;
      cnt         <= 16'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
    end else begin
      state       <= state_nxt;
      awvalid     <= awvalid_nxt;
      wvalid      <= wvalid_nxt;
      arvalid     <= arvalid_nxt;
      rsp_valid   <= rsp_set;
      rsp_timeout <= rsp_to_set;
      if (rsp_set) begin
        rsp_rdata <= rsp_rdata_set;
        rsp_resp  <= rsp_resp_set;
      end
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        cnt     <= 16'd0;
      end else if (state != S_IDLE) begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// tb/tb_axi4lite_master_bridge.sv - randomized bench for axi4lite_master_bridge against a delay-arithmetic model
// Each transaction's response cycle and content are predicted from the slave's chosen ready/valid delays.
module tb_axi4lite_master_bridge;

  localparam int AW = 3;
  localparam int TO = 8;
  localparam int WINDOW = 12;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;

  always #5 aclk = ~aclk;

  axi4lite_master_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = 32'd0;
  endtask

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Delays count cycles after acceptance: ready rises in cycle 1+d; B/R valid rises d cycles after the slave's side is ready.
  task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int aw_d, input int w_d, input int b_d, input int ar_d, input int r_d,
                         input logic [1:0] sresp, input logic [31:0] srdata);
    int c_done, exp_cyc, exp_aw, exp_w, exp_ar;
    bit exp_to;
    logic [1:0] exp_resp;
    logic [31:0] exp_rdata;
    int aw_hs, w_hs, ar_hs, aw_n, w_n, b_n, ar_n, r_n, rsp_n, rsp_cyc;
    logic [1:0] got_resp;
    logic [31:0] got_rdata;
    logic got_to;

    if (wr) c_done = max2(1 + aw_d, 1 + w_d) + 1 + b_d;
    else    c_done = 1 + ar_d + 1 + r_d;
    exp_to    = (c_done > TO);
    exp_cyc   = exp_to ? TO + 1 : c_done + 1;
    exp_resp  = exp_to ? 2'b10 : sresp;
    exp_rdata = (exp_to || wr) ? 32'd0 : srdata;
    exp_aw    = (wr && 1 + aw_d <= TO) ? 1 : 0;
    exp_w     = (wr && 1 + w_d <= TO) ? 1 : 0;
    exp_ar    = (!wr && 1 + ar_d <= TO) ? 1 : 0;

    aw_hs = -1; w_hs = -1; ar_hs = -1;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; rsp_n = 0; rsp_cyc = -1;
    got_resp = 2'b00; got_rdata = 32'd0; got_to = 1'b0;

    @(negedge aclk);
    slave_idle();
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = ws;
    #1;
    check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge aclk);

    for (int cyc = 1; cyc <= WINDOW; cyc++) begin
      @(negedge aclk);
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      awready = (cyc >= 1 + aw_d);
      wready  = (cyc >= 1 + w_d);
      arready = (cyc >= 1 + ar_d);
      bvalid  = (aw_hs >= 0 && w_hs >= 0 && cyc >= max2(aw_hs, w_hs) + 1 + b_d && b_n == 0);
      bresp   = bvalid ? sresp : 2'b00;
      rvalid  = (ar_hs >= 0 && cyc >= ar_hs + 1 + r_d && r_n == 0);
      rresp   = rvalid ? sresp : 2'b00;
      rdata   = rvalid ? srdata : $urandom;
      #1;
      if (awvalid) check_eq("awaddr_stable", {29'd0, awaddr}, {29'd0, a});
      if (wvalid) begin
        check_eq("wdata_stable", wdata, wd);
        check_eq("wstrb_stable", {28'd0, wstrb}, {28'd0, ws});
      end
      if (arvalid) check_eq("araddr_stable", {29'd0, araddr}, {29'd0, a});
      if (cyc == 1) check_eq("prot_zero", {26'd0, awprot, arprot}, 32'd0);
      check_eq("bready_early", {31'd0, bready && !(aw_n == 1 && w_n == 1)}, 32'd0);
      check_eq("to_qualified", {31'd0, rsp_timeout && !rsp_valid}, 32'd0);
      if (cyc == exp_cyc) check_eq("req_ready_at_rsp", {31'd0, req_ready}, 32'd1);
      if (cyc >= exp_cyc)
        check_eq("axi_quiet", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
      if (rsp_valid) begin
        rsp_n++;
        if (rsp_cyc < 0) begin
          rsp_cyc = cyc; got_resp = rsp_resp; got_rdata = rsp_rdata; got_to = rsp_timeout;
        end
      end
      if (awvalid && awready) begin aw_n++; if (aw_hs < 0) aw_hs = cyc; end
      if (wvalid && wready)   begin w_n++;  if (w_hs < 0)  w_hs = cyc;  end
      if (arvalid && arready) begin ar_n++; if (ar_hs < 0) ar_hs = cyc; end
      if (bvalid && bready) b_n++;
      if (rvalid && rready) r_n++;
    end

    check_eq("rsp_cycle", rsp_cyc, exp_cyc);
    check_eq("rsp_pulses", rsp_n, 1);
    check_eq("rsp_resp", {30'd0, got_resp}, {30'd0, exp_resp});
    check_eq("rsp_rdata", got_rdata, exp_rdata);
    check_eq("rsp_timeout", {31'd0, got_to}, {31'd0, exp_to});
    check_eq("aw_hs_count", aw_n, exp_aw);
    check_eq("w_hs_count", w_n, exp_w);
    check_eq("ar_hs_count", ar_n, exp_ar);
    check_eq("b_hs_count", b_n, (wr && !exp_to) ? 1 : 0);
    check_eq("r_hs_count", r_n, (!wr && !exp_to) ? 1 : 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {25'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_timeout}, 32'd0);
    check_eq({tag, "_rdata"}, rsp_rdata, 32'd0);
    check_eq({tag, "_resp"}, {30'd0, rsp_resp}, 32'd0);
    check_eq({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int d [5];
    bit wr;

    areset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = 32'd0; req_wstrb = 4'd0;
    slave_idle();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_all_zero("reset_state");
    areset_n = 1'b1;

    run_txn(1'b1, 3'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'd0);
    run_txn(1'b0, 3'h0, 32'd0, 4'h0, 0, 0, 0, 0, 1, 2'b00, 32'h12345678);
    run_txn(1'b1, 3'h2, 32'hA5A5_0F0F, 4'h3, 0, 5, 0, 0, 0, 2'b00, 32'd0);
    run_txn(1'b1, 3'h6, 32'h0BAD_F00D, 4'hC, 1, 0, 1, 0, 0, 2'b10, 32'd0);
    run_txn(1'b0, 3'h1, 32'd0, 4'h0, 0, 0, 0, 20, 0, 2'b00, 32'hFFFF_FFFF);
    run_txn(1'b0, 3'h3, 32'd0, 4'h0, 0, 0, 0, 0, 6, 2'b01, 32'hCAFE_0001);
    run_txn(1'b0, 3'h3, 32'd0, 4'h0, 0, 0, 0, 0, 7, 2'b00, 32'hCAFE_0002);
    run_txn(1'b1, 3'h5, 32'h1111_2222, 4'h1, 2, 2, 5, 0, 0, 2'b00, 32'd0);
    run_txn(1'b1, 3'h7, 32'h3333_4444, 4'h8, 7, 1, 0, 0, 0, 2'b00, 32'd0);

    // Reset during WRESP: the pending write is discarded and a late B beat is ignored.
    @(negedge aclk);
    slave_idle();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'h4; req_wdata = 32'h7777_8888; req_wstrb = 4'hF;
    @(posedge aclk);
    @(negedge aclk);
    req_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    @(negedge aclk);
    awready = 1'b0; wready = 1'b0;
    #1;
    check_eq("wresp_bready", {31'd0, bready}, 32'd1);
    areset_n = 1'b0;
    @(negedge aclk);
    areset_n = 1'b1;
    #1;
    check_all_zero("mid_reset");
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      bvalid = 1'b1; bresp = 2'b00;
      #1;
      check_eq("post_reset_silent", {30'd0, rsp_valid, bready}, 32'd0);
    end
    @(negedge aclk);
    slave_idle();
    run_txn(1'b0, 3'h4, 32'd0, 4'h0, 0, 0, 0, 1, 0, 2'b00, 32'h5555_AAAA);

    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom);
      for (int k = 0; k < 5; k++) d[k] = $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0) d[$urandom_range(0, 4)] = 20;
      run_txn(wr, AW'($urandom), $urandom, 4'($urandom), d[0], d[1], d[2], d[3], d[4],
              2'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
